// File: rtl/apple2_video_pkg.sv
// Shared constants, character classes and pipeline payload for the Apple II text scanout.
package apple2_video_pkg;

  localparam int unsigned GLYPH_W  = 8;
  localparam int unsigned GLYPH_H  = 8;
  localparam int unsigned PIPE_LAT = 4;

  localparam logic [23:0] DEF_FG_RGB     = 24'hFFFFFF;
  localparam logic [23:0] DEF_BG_RGB     = 24'h30B030;
  localparam logic [23:0] DEF_BORDER_RGB = 24'h000000;

  typedef enum logic [1:0] {
    CLS_INVERSE = 2'b00,
    CLS_FLASH   = 2'b01,
    CLS_NORMAL  = 2'b10
  } char_cls_e;

  // Per-pixel side information carried alongside the VRAM/font fetches
  typedef struct packed {
    logic      de;
    logic      hs;
    logic      vs;
    logic      show;
    logic [2:0] glyph_row;
    logic [2:0] bit_idx;
    char_cls_e cls;
  } pix_meta_t;

  function automatic char_cls_e classify(input logic [7:0] code);
    case (code[7:6])
      2'b00:   return CLS_INVERSE;
      2'b01:   return CLS_FLASH;
      default: return CLS_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/apple2_flash_timer.sv
// Frame-boundary logic: vs rising-edge detect, flash frame counter/phase and page latch.
module apple2_flash_timer #(
  parameter int unsigned FLASH_FRAMES = 16
) (
  input  logic pix_clk,
  input  logic rst,
  input  logic vs,
  input  logic page,
  output logic flash_phase,
  output logic page_q
);

  localparam int unsigned CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FLASH_FRAMES - 1);

  logic             vs_q;
  logic [CNT_W-1:0] frame_cnt;

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      vs_q        <= 1'b0;
      frame_cnt   <= '0;
      flash_phase <= 1'b0;
      page_q      <= 1'b0;
    end else begin
      vs_q <= vs;
      if (vs && !vs_q) begin
        page_q <= page;
        if (frame_cnt == LAST) begin
          frame_cnt   <= '0;
          flash_phase <= ~flash_phase;
        end else begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/apple2_text_scanout.sv
// Apple II style text-mode scanout: beam position -> VRAM -> font ROM -> RGB, four-stage pipeline.
module apple2_text_scanout
  import apple2_video_pkg::*;
#(
  parameter int unsigned COLS         = 40,
  parameter int unsigned ROWS         = 24,
  parameter int unsigned H_SCALE      = 2,
  parameter int unsigned V_SCALE      = 2,
  parameter logic [15:0] BASE_ADDR    = 16'h0400,
  parameter logic [15:0] PAGE_STRIDE  = 16'h0400,
  parameter int unsigned FLASH_FRAMES = 16,
  parameter logic [23:0] FG_RGB       = DEF_FG_RGB,
  parameter logic [23:0] BG_RGB       = DEF_BG_RGB,
  parameter logic [23:0] BORDER_RGB   = DEF_BORDER_RGB
) (
  input  logic               i_pix_clk,
  input  logic               i_rst,
  input  logic               i_de,
  input  logic               i_hs,
  input  logic               i_vs,
  input  logic signed [15:0] i_sx,
  input  logic signed [15:0] i_sy,
  input  logic               i_page,
  input  logic               i_enable,
  output logic [15:0]        o_vram_addr,
  output logic               o_vram_en,
  input  logic [7:0]         i_vram_data,
  output logic [9:0]         o_font_addr,
  input  logic [7:0]         i_font_data,
  output logic [7:0]         o_r,
  output logic [7:0]         o_g,
  output logic [7:0]         o_b,
  output logic               o_de,
  output logic               o_hs,
  output logic               o_vs
);

  localparam int unsigned CELL_W = GLYPH_W * H_SCALE;
  localparam int unsigned CELL_H = GLYPH_H * V_SCALE;
  localparam int unsigned WIN_W  = COLS * CELL_W;
  localparam int unsigned WIN_H  = ROWS * CELL_H;

  logic               s0_de, s0_hs, s0_vs, s0_en;
  logic signed [15:0] s0_sx, s0_sy;
  pix_meta_t          meta_q [PIPE_LAT-1];
  logic [7:0]         font_q;
  logic               flash_phase, page_q;

  logic [15:0] sx_u, sy_u, page_base;
  logic        in_win, fetch_c;
  int unsigned col, trow;
  logic [2:0]  glyph_row, bit_idx;
  logic [15:0] vram_addr_c;
  pix_meta_t   m1_c, m2_c;
  logic        font_bit, inverse, pixel_on;
  logic [23:0] rgb_c;

  apple2_flash_timer #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_flash_timer (
    .pix_clk     (i_pix_clk),
    .rst         (i_rst),
    .vs          (i_vs),
    .page        (i_page),
    .flash_phase (flash_phase),
    .page_q      (page_q)
  );

  // Decode the sampled beam position into window flag, cell coordinates and VRAM address
  always_comb begin
    sx_u      = s0_sx;
    sy_u      = s0_sy;
    in_win    = !s0_sx[15] && !s0_sy[15] && (32'(sx_u) < WIN_W) && (32'(sy_u) < WIN_H);
    col       = 32'(sx_u) / CELL_W;
    trow      = 32'(sy_u) / CELL_H;
    if (col > COLS - 1)  col  = COLS - 1;
    if (trow > ROWS - 1) trow = ROWS - 1;
    glyph_row = 3'((32'(sy_u) / V_SCALE) % GLYPH_H);
    bit_idx   = 3'((32'(sx_u) / H_SCALE) % GLYPH_W);
    page_base = BASE_ADDR + (page_q ? PAGE_STRIDE : 16'h0000);
    // Apple II interleave: eight 128-byte groups, three 40-byte rows per group
    vram_addr_c = page_base + 16'(128 * (trow % 8)) + 16'(40 * (trow / 8)) + 16'(col);
    fetch_c   = s0_de && s0_en && in_win;
    m1_c      = '{de: s0_de, hs: s0_hs, vs: s0_vs, show: in_win && s0_en,
                  glyph_row: glyph_row, bit_idx: bit_idx, cls: CLS_NORMAL};
    m2_c      = meta_q[0];
    m2_c.cls  = classify(i_vram_data);
  end

  // Final pixel colour from the fetched glyph row
  always_comb begin
    font_bit = font_q[~meta_q[2].bit_idx];
    case (meta_q[2].cls)
      CLS_INVERSE: inverse = 1'b1;
      CLS_FLASH:   inverse = flash_phase;
      default:     inverse = 1'b0;
    endcase
    pixel_on = font_bit ^ inverse;
    if (!meta_q[2].de)        rgb_c = 24'h000000;
    else if (!meta_q[2].show) rgb_c = BORDER_RGB;
    else if (pixel_on)        rgb_c = FG_RGB;
    else                      rgb_c = BG_RGB;
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      s0_de       <= 1'b0;
      s0_hs       <= 1'b0;
      s0_vs       <= 1'b0;
      s0_en       <= 1'b0;
      s0_sx       <= '0;
      s0_sy       <= '0;
      for (int i = 0; i < int'(PIPE_LAT) - 1; i++) meta_q[i] <= '0;
      font_q      <= '0;
      o_vram_addr <= BASE_ADDR;
      o_vram_en   <= 1'b0;
      o_font_addr <= '0;
      {o_r, o_g, o_b} <= 24'h000000;
      o_de        <= 1'b0;
      o_hs        <= 1'b0;
      o_vs        <= 1'b0;
    end else begin
      s0_de <= i_de;
      s0_hs <= i_hs;
      s0_vs <= i_vs;
      s0_en <= i_enable;
      s0_sx <= i_sx;
      s0_sy <= i_sy;

      o_vram_en <= fetch_c;
      if (fetch_c) o_vram_addr <= vram_addr_c;
      meta_q[0] <= m1_c;

      o_font_addr <= {i_vram_data[6:0], meta_q[0].glyph_row};
      meta_q[1]   <= m2_c;

      font_q    <= i_font_data;
      meta_q[2] <= meta_q[1];

      {o_r, o_g, o_b} <= rgb_c;
      o_de <= meta_q[2].de;
      o_hs <= meta_q[2].hs;
      o_vs <= meta_q[2].vs;
    end
  end

endmodule

// File: tb/tb_apple2_text_scanout.sv
// Directed bench for apple2_text_scanout: VRAM/font models, per-edge output history, hand-computed checks.
module tb_apple2_text_scanout;

  localparam logic [23:0] FG  = 24'hFFFFFF;
  localparam logic [23:0] BG  = 24'h30B030;
  localparam logic [23:0] BRD = 24'h102030;
  localparam int HN = 1024;

  logic               pix_clk = 1'b0;
  logic               rst, de, hs, vs, page, enable;
  logic signed [15:0] sx, sy;
  logic [15:0]        vram_addr;
  logic               vram_en;
  logic [7:0]         vram_data, font_data;
  logic [9:0]         font_addr;
  logic [7:0]         r, g, b;
  logic               o_de, o_hs, o_vs;

  logic [7:0] vram_mem [65536];
  logic [7:0] font_mem [1024];

  logic [15:0] h_addr [HN];
  logic        h_en   [HN];
  logic [9:0]  h_fa   [HN];
  logic [23:0] h_rgb  [HN];
  logic        h_de   [HN];
  logic        h_hs   [HN];
  logic        h_vs   [HN];
  int          cyc = 0;

  int n_vec = 0;
  int n_err = 0;

  apple2_text_scanout #(
    .FLASH_FRAMES (2),
    .BORDER_RGB   (BRD)
  ) dut (
    .i_pix_clk   (pix_clk),
    .i_rst       (rst),
    .i_de        (de),
    .i_hs        (hs),
    .i_vs        (vs),
    .i_sx        (sx),
    .i_sy        (sy),
    .i_page      (page),
    .i_enable    (enable),
    .o_vram_addr (vram_addr),
    .o_vram_en   (vram_en),
    .i_vram_data (vram_data),
    .o_font_addr (font_addr),
    .i_font_data (font_data),
    .o_r         (r),
    .o_g         (g),
    .o_b         (b),
    .o_de        (o_de),
    .o_hs        (o_hs),
    .o_vs        (o_vs)
  );

  always #5 pix_clk = ~pix_clk;

  // Registered-address memories: data follows the address register after each edge
  assign vram_data = vram_mem[vram_addr];
  assign font_data = font_mem[font_addr];

  always @(posedge pix_clk) begin
    #1;
    cyc = cyc + 1;
    if (cyc < HN) begin
      h_addr[cyc] = vram_addr;
      h_en[cyc]   = vram_en;
      h_fa[cyc]   = font_addr;
      h_rgb[cyc]  = {r, g, b};
      h_de[cyc]   = o_de;
      h_hs[cyc]   = o_hs;
      h_vs[cyc]   = o_vs;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one pixel; n is the index of the edge that samples it
  task automatic px(input int x, input int y, input logic d, output int n);
    sx = 16'(x);
    sy = 16'(y);
    de = d;
    n  = cyc + 1;
    @(negedge pix_clk);
  endtask

  task automatic idle(input int k);
    int n;
    for (int i = 0; i < k; i++) px(0, 0, 1'b0, n);
  endtask

  task automatic vs_pulse(output int n);
    vs = 1'b1;
    px(0, 0, 1'b0, n);
    vs = 1'b0;
    idle(6);
  endtask

  task automatic flash_probe(input string tag, input logic [23:0] exp);
    int n;
    px(32, 0, 1'b1, n);
    idle(6);
    check(tag, 32'(h_rgb[n+4]), 32'(exp));
  endtask

  int n0 [16];
  int na, nb, nc, nd, ne, nv, m, nr;

  initial begin
    for (int i = 0; i < 65536; i++) vram_mem[i] = 8'h00;
    for (int i = 0; i < 1024; i++)  font_mem[i] = 8'h00;
    vram_mem[16'h0400] = 8'hC1;
    vram_mem[16'h0401] = 8'h01;
    vram_mem[16'h0402] = 8'h41;
    font_mem[10'h208]  = 8'h80;
    font_mem[10'h008]  = 8'h80;

    rst = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; page = 1'b0; enable = 1'b1;
    sx = '0; sy = '0;
    repeat (3) @(negedge pix_clk);
    check("rst_addr", 32'(vram_addr), 32'h0400);
    check("rst_en",   32'(vram_en),   32'h0);
    check("rst_fa",   32'(font_addr), 32'h0);
    check("rst_de",   32'(o_de),      32'h0);
    check("rst_rgb",  32'({r, g, b}), 32'h0);
    rst = 1'b0;
    idle(2);

    // First line of cell (0,0): 'A' normal, only glyph bit 0 lit
    for (int x = 0; x < 16; x++) px(x, 0, 1'b1, n0[x]);
    idle(6);
    check("c0_addr", 32'(h_addr[n0[0]+1]), 32'h0400);
    check("c0_en",   32'(h_en[n0[0]+1]),   32'h1);
    check("c0_fa",   32'(h_fa[n0[0]+2]),   32'h208);
    check("c0_lat",  32'(h_de[n0[0]+3]),   32'h0);
    check("c0_de",   32'(h_de[n0[0]+4]),   32'h1);
    check("c0_px0",  32'(h_rgb[n0[0]+4]),  32'(FG));
    check("c0_px1",  32'(h_rgb[n0[1]+4]),  32'(FG));
    for (int x = 2; x < 16; x++) check($sformatf("c0_px%0d", x), 32'(h_rgb[n0[x]+4]), 32'(BG));

    // Interleaved row addressing
    px(624, 128, 1'b1, na);
    px(0, 368, 1'b1, nb);
    idle(6);
    check("r8c39",  32'(h_addr[na+1]), 32'h044F);
    check("r23c0",  32'(h_addr[nb+1]), 32'h07D0);
    check("r23_en", 32'(h_en[nb+1]),   32'h1);

    // Inverse character
    px(16, 0, 1'b1, na);
    px(18, 0, 1'b1, nb);
    idle(6);
    check("inv_px0", 32'(h_rgb[na+4]), 32'(BG));
    check("inv_px1", 32'(h_rgb[nb+4]), 32'(FG));

    // Flash character, two frames per phase
    flash_probe("fl_f0", FG);
    vs_pulse(nv);
    check("vs_lat", 32'(h_vs[nv+3]), 32'h0);
    check("vs_out", 32'(h_vs[nv+4]), 32'h1);
    flash_probe("fl_f1", FG);
    vs_pulse(nv);
    flash_probe("fl_f2", BG);
    vs_pulse(nv);
    flash_probe("fl_f3", BG);
    vs_pulse(nv);
    flash_probe("fl_f4", FG);

    // Page change mid-frame waits for the next vs edge
    page = 1'b1;
    px(0, 100, 1'b1, na);
    idle(6);
    check("pg_hold", 32'(h_addr[na+1]), 32'h0700);
    vs_pulse(nv);
    px(0, 0, 1'b1, nb);
    px(0, 100, 1'b1, nc);
    idle(6);
    check("pg2_r0", 32'(h_addr[nb+1]), 32'h0800);
    check("pg2_r6", 32'(h_addr[nc+1]), 32'h0B00);

    // Border, negative position, text disabled, blanking
    hs = 1'b1;
    px(700, 0, 1'b1, na);
    hs = 1'b0;
    px(-5, 0, 1'b1, nb);
    enable = 1'b0;
    px(0, 0, 1'b1, nc);
    enable = 1'b1;
    px(0, 0, 1'b0, nd);
    idle(6);
    check("brd_en",   32'(h_en[na+1]),   32'h0);
    check("brd_hold", 32'(h_addr[na+1]), 32'h0B00);
    check("brd_rgb",  32'(h_rgb[na+4]),  32'(BRD));
    check("brd_de",   32'(h_de[na+4]),   32'h1);
    check("hs_lat",   32'(h_hs[na+3]),   32'h0);
    check("hs_out",   32'(h_hs[na+4]),   32'h1);
    check("neg_en",   32'(h_en[nb+1]),   32'h0);
    check("neg_rgb",  32'(h_rgb[nb+4]),  32'(BRD));
    check("dis_en",   32'(h_en[nc+1]),   32'h0);
    check("dis_addr", 32'(h_addr[nc+1]), 32'h0B00);
    check("dis_rgb",  32'(h_rgb[nc+4]),  32'(BRD));
    check("blk_rgb",  32'(h_rgb[nd+4]),  32'h0);
    check("blk_de",   32'(h_de[nd+4]),   32'h0);

    // Reset mid-line, then recovery latency
    for (int x = 40; x < 50; x++) px(x, 0, 1'b1, ne);
    rst = 1'b1;
    px(50, 0, 1'b1, nr);
    px(51, 0, 1'b1, ne);
    rst = 1'b0;
    px(0, 0, 1'b1, m);
    idle(6);
    check("pre_rst_de", 32'(h_de[nr-1]),   32'h1);
    check("rst_de_now", 32'(h_de[nr]),     32'h0);
    check("rst_rgb_now",32'(h_rgb[nr]),    32'h0);
    check("rst_addr_now",32'(h_addr[nr]),  32'h0400);
    check("rec_addr",   32'(h_addr[m+1]),  32'h0400);
    check("rec_lat",    32'(h_de[m+3]),    32'h0);
    check("rec_de",     32'(h_de[m+4]),    32'h1);
    check("rec_rgb",    32'(h_rgb[m+4]),   32'(FG));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
